// File: rtl/tlul_pkg.sv
// ============================================================================
// Module   : tlul_pkg
// Purpose  : TL-UL channel types, opcodes and default values.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = 4;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic       cap;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [13:0]       d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

    localparam tl_h2d_t TL_H2D_DEFAULT = '{
        a_valid:   1'b0,
        a_opcode:  Get,
        a_param:   3'h0,
        a_size:    2'h0,
        a_source:  8'h0,
        a_address: 32'h0,
        a_mask:    4'h0,
        a_data:    32'h0,
        a_user:    '{cap: 1'b0, cmd_intg: 7'h0, data_intg: 7'h0},
        d_ready:   1'b1
    };

endpackage

`default_nettype wire

// File: rtl/tlul_word_copier_pkg.sv
// ============================================================================
// Module   : tlul_word_copier_pkg
// Purpose  : State encoding and constants for the TL-UL word copier.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tlul_word_copier_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        RD_RSP = 3'd2,
        WR_REQ = 3'd3,
        WR_RSP = 3'd4,
        DONE   = 3'd5
    } copier_state_e;

    localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

`default_nettype wire

// File: rtl/tlul_cmd_intg_gen.sv
// ============================================================================
// Module   : tlul_cmd_intg_gen
// Purpose  : Fills a_user.cmd_intg with a Hamming-style code over the A command.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tlul_cmd_intg_gen
    import tlul_pkg::*;
(
    input  tl_h2d_t i_tl,
    output tl_h2d_t o_tl
);

    localparam int c_PAYLOAD_W = TL_AW + 3 + TL_DBW + 1;

    logic [c_PAYLOAD_W-1:0] w_payload;
    logic [6:0]             w_intg;

    // Bit b covers payload positions whose (index+1) has bit b set; bit 6 is overall parity.
    always_comb begin
        w_payload = {i_tl.a_user.cap, i_tl.a_opcode, i_tl.a_mask, i_tl.a_address};
        w_intg    = '0;
        for (int b = 0; b < 6; b++) begin
            for (int j = 0; j < c_PAYLOAD_W; j++) begin
                if ((((j + 1) >> b) & 1) != 0) begin
                    w_intg[b] = w_intg[b] ^ w_payload[j];
                end
            end
        end
        w_intg[6] = ^{w_payload, w_intg[5:0]};
        o_tl                 = i_tl;
        o_tl.a_user.cmd_intg = w_intg;
    end

endmodule

`default_nettype wire

// File: rtl/tlul_word_copier.sv
// ============================================================================
// Module   : tlul_word_copier
// Purpose  : TL-UL host copying a block of 32-bit words, one Get then one Put per word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tlul_word_copier
    import tlul_pkg::*;
    import tlul_word_copier_pkg::*;
#(
    parameter int unsigned       LenWidth = 16,
    parameter logic [TL_AIW-1:0] SourceId = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [31:0]         src_addr_i,
    input  logic [31:0]         dst_addr_i,
    input  logic [LenWidth-1:0] len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output tl_h2d_t             tl_o,
    input  tl_d2h_t             tl_i
);

    copier_state_e       r_state;
    copier_state_e       w_state_nxt;
    logic [31:0]         r_src;
    logic [31:0]         r_dst;
    logic [31:0]         r_data;
    logic [LenWidth-1:0] r_remaining;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                w_rsp_hit;
    logic                w_last_word;
    logic                w_unused_d;
    tl_h2d_t             w_tl_raw;

    // Responses tagged with another source belong to someone else and are dropped.
    assign w_rsp_hit   = tl_i.d_valid && (tl_i.d_source == SourceId);
    assign w_last_word = (r_remaining == LenWidth'(1));
    assign w_unused_d  = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (start_i) w_state_nxt = (len_i == '0) ? DONE : RD_REQ;
            RD_REQ: if (tl_i.a_ready) w_state_nxt = RD_RSP;
            RD_RSP: if (w_rsp_hit) w_state_nxt = tl_i.d_error ? DONE : WR_REQ;
            WR_REQ: if (tl_i.a_ready) w_state_nxt = WR_RSP;
            WR_RSP: begin
                if (w_rsp_hit) begin
                    w_state_nxt = (tl_i.d_error || w_last_word) ? DONE : RD_REQ;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_data      <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_src       <= {src_addr_i[31:2], 2'b00};
                        r_dst       <= {dst_addr_i[31:2], 2'b00};
                        r_remaining <= len_i;
                        r_err       <= 1'b0;
                        r_busy      <= (len_i != '0);
                    end
                end
                RD_RSP: begin
                    if (w_rsp_hit) begin
                        if (tl_i.d_error) r_err <= 1'b1;
                        else              r_data <= tl_i.d_data;
                    end
                end
                WR_RSP: begin
                    if (w_rsp_hit) begin
                        if (tl_i.d_error) begin
                            r_err <= 1'b1;
                        end else begin
                            r_src       <= r_src + WORD_STRIDE;
                            r_dst       <= r_dst + WORD_STRIDE;
                            r_remaining <= r_remaining - LenWidth'(1);
                        end
                    end
                end
                DONE:    r_busy <= 1'b0;
                default: ;
            endcase
        end
    end

    // A fields depend only on registered state, so D inputs never reach the A channel.
    always_comb begin
        w_tl_raw             = TL_H2D_DEFAULT;
        w_tl_raw.a_size      = 2'd2;
        w_tl_raw.a_mask      = 4'hF;
        w_tl_raw.a_source    = SourceId;
        w_tl_raw.a_address   = r_src;
        w_tl_raw.a_user.cap  = 1'b0;
        case (r_state)
            RD_REQ: begin
                w_tl_raw.a_valid  = 1'b1;
                w_tl_raw.a_opcode = Get;
            end
            WR_REQ: begin
                w_tl_raw.a_valid   = 1'b1;
                w_tl_raw.a_opcode  = PutFullData;
                w_tl_raw.a_address = r_dst;
                w_tl_raw.a_data    = r_data;
            end
            default: ;
        endcase
    end

    tlul_cmd_intg_gen u_cmd_intg (
        .i_tl (w_tl_raw),
        .o_tl (tl_o)
    );

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign err_o  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tlul_word_copier.sv
// ============================================================================
// Module   : tb_tlul_word_copier
// Purpose  : Self-checking bench for tlul_word_copier against a zero/N-wait SRAM model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tlul_word_copier;
    import tlul_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    tl_h2d_t     tl_o;
    tl_d2h_t     tl_i;

    always #5 clk_i = ~clk_i;

    tlul_word_copier dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .src_addr_i (src_addr),
        .dst_addr_i (dst_addr),
        .len_i      (len),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .tl_o       (tl_o),
        .tl_i       (tl_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    int cfg_stall   = 0;
    int cfg_err_get = -1;
    int s_get_cnt   = 0;
    int s_stall_cnt = 0;
    int n_unstable  = 0;
    int n_done      = 0;
    int n_avalid    = 0;
    int n_busy      = 0;
    logic    s_hs_pending;
    logic    s_prev_stall;
    txn_t    s_pend;
    tl_h2d_t s_prev_tl;

    logic [31:0] mem [logic [31:0]];
    txn_t q_obs[$];
    txn_t q_exp[$];
    int   obs_idx = 0;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    // SRAM slave: drives a_ready/D at negedge, one response the cycle after each handshake.
    always @(negedge clk_i) begin
        if (rst_ni !== 1'b1) begin
            tl_i         = '0;
            s_hs_pending = 1'b0;
            s_prev_stall = 1'b0;
            s_stall_cnt  = 0;
        end else begin
            if (done_o) n_done++;
            if (busy_o) n_busy++;
            if (tl_o.a_valid) n_avalid++;
            if (tl_o.a_valid && s_prev_stall && (tl_o !== s_prev_tl)) n_unstable++;
            tl_i.d_valid = 1'b0;
            tl_i.d_error = 1'b0;
            if (s_hs_pending) begin
                tl_i.d_valid  = 1'b1;
                tl_i.d_source = '0;
                tl_i.d_size   = 2'd2;
                if (s_pend.op == 3'h4) begin
                    tl_i.d_opcode = AccessAckData;
                    tl_i.d_data   = mem.exists(s_pend.addr) ? mem[s_pend.addr] : pattern(s_pend.addr);
                    tl_i.d_error  = (s_get_cnt == cfg_err_get);
                end else begin
                    tl_i.d_opcode = AccessAck;
                    tl_i.d_data   = '0;
                end
                s_hs_pending = 1'b0;
            end
            if (tl_o.a_valid) begin
                if (s_stall_cnt < cfg_stall) begin
                    tl_i.a_ready = 1'b0;
                    s_stall_cnt++;
                    s_prev_stall = 1'b1;
                end else begin
                    tl_i.a_ready = 1'b1;
                    s_stall_cnt  = 0;
                    s_prev_stall = 1'b0;
                    s_pend.op    = tl_o.a_opcode;
                    s_pend.addr  = tl_o.a_address;
                    s_pend.data  = (tl_o.a_opcode == PutFullData) ? tl_o.a_data : 32'h0;
                    if (tl_o.a_opcode == PutFullData) mem[tl_o.a_address] = tl_o.a_data;
                    if (tl_o.a_opcode == Get) s_get_cnt++;
                    q_obs.push_back(s_pend);
                    s_hs_pending = 1'b1;
                end
                s_prev_tl = tl_o;
            end else begin
                tl_i.a_ready = 1'b0;
                s_prev_stall = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int n, input int stall, input int err_word, input bit mid_start);
        int   n_exp;
        int   obs_start;
        int   done0;
        int   dly;
        logic done_seen;
        txn_t e;
        txn_t o;
        cfg_stall   = stall;
        cfg_err_get = (err_word > 0) ? s_get_cnt + err_word : -1;
        for (int i = 0; i < n; i++) begin
            q_exp.push_back(txn_t'{op: 3'h4, addr: src + 32'(4 * i), data: 32'h0});
            if (err_word == i + 1) break;
            q_exp.push_back(txn_t'{op: 3'h0, addr: dst + 32'(4 * i), data: pattern(src + 32'(4 * i))});
        end
        n_exp     = q_exp.size();
        obs_start = q_obs.size();
        done0     = n_done;
        src_addr  = src;
        dst_addr  = dst;
        len       = 16'(n);
        start_i   = 1'b1;
        tick(1);
        start_i = 1'b0;
        check({tag, " first a_valid"}, tl_o.a_valid, n > 0);
        check({tag, " first busy"}, busy_o, n > 0);
        check({tag, " err cleared"}, err_o, 1'b0);
        dly       = 1;
        done_seen = done_o;
        while (!done_seen && dly < 400) begin
            if (mid_start) begin
                start_i = (dly == 3);
                if (dly == 3) begin
                    src_addr = 32'h0060_0000;
                    dst_addr = 32'h0061_0000;
                    len      = 16'd7;
                end
            end
            tick(1);
            dly++;
            done_seen = done_o;
        end
        start_i = 1'b0;
        check({tag, " done seen"}, done_seen, 1'b1);
        if (err_word == 0) check({tag, " latency"}, dly, 4 * n + 2 + 2 * n * stall);
        tick(6);
        check({tag, " done pulses"}, n_done - done0, 1);
        check({tag, " err_o"}, err_o, err_word > 0);
        check({tag, " txn count"}, q_obs.size() - obs_start, n_exp);
        obs_idx = obs_start;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            if (obs_idx < q_obs.size()) o = q_obs[obs_idx];
            else                        o = '1;
            obs_idx++;
            check({tag, " txn"}, o, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int av0;
        int bz0;
        int wait_cnt;
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        tick(3);
        check("reset a_valid", tl_o.a_valid, 1'b0);
        check("reset d_ready", tl_o.d_ready, 1'b1);
        check("reset busy", busy_o, 1'b0);
        check("reset done", done_o, 1'b0);
        check("reset err", err_o, 1'b0);
        #1 rst_ni = 1'b1;
        tick(2);

        run_copy("T1", 32'h0010_0000, 32'h0010_1000, 4, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("T1 dst mem", mem[32'h0010_1000 + 32'(4 * i)], pattern(32'h0010_0000 + 32'(4 * i)));
        end

        av0 = n_avalid;
        bz0 = n_busy;
        run_copy("T2", 32'h0020_0000, 32'h0020_1000, 0, 0, 0, 1'b0);
        check("T2 no a_valid", n_avalid - av0, 0);
        check("T2 no busy", n_busy - bz0, 0);

        run_copy("T3", 32'h0030_0000, 32'h0031_0000, 4, 0, 2, 1'b0);
        run_copy("T3 recover", 32'h0032_0000, 32'h0033_0000, 1, 0, 0, 1'b0);

        run_copy("T4", 32'h0040_0000, 32'h0041_0000, 2, 3, 0, 1'b0);
        check("T4 stable A", n_unstable, 0);

        run_copy("T5", 32'hFFFF_FFF8, 32'h2000_0000, 3, 0, 0, 1'b0);

        run_copy("T6 ignore", 32'h0050_0000, 32'h0051_0000, 4, 0, 0, 1'b1);

        cfg_stall = 3;
        src_addr  = 32'h0080_0000;
        dst_addr  = 32'h0081_0000;
        len       = 16'd2;
        start_i   = 1'b1;
        tick(1);
        start_i  = 1'b0;
        wait_cnt = 0;
        while (!(tl_o.a_valid && tl_o.a_opcode == PutFullData) && wait_cnt < 100) begin
            tick(1);
            wait_cnt++;
        end
        check("T6 reached WR_REQ", wait_cnt < 100, 1'b1);
        #1 rst_ni = 1'b0;
        #1;
        check("T6 rst a_valid", tl_o.a_valid, 1'b0);
        check("T6 rst busy", busy_o, 1'b0);
        tick(2);
        #1 rst_ni = 1'b1;
        tick(2);
        check("T6 post a_valid", tl_o.a_valid, 1'b0);
        check("T6 post busy", busy_o, 1'b0);
        check("T6 post done", done_o, 1'b0);
        obs_idx = q_obs.size();
        run_copy("T6 idle", 32'h0090_0000, 32'h0091_0000, 1, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
